// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode and control-select types for the multi-cycle RISC-V controller.
package rv_ctrl_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_FAULT  = 3'd4
    } ctrl_state_t;
    typedef enum logic {ADD = 1'b0, SUB = 1'b1} alu_op_t;
    typedef enum logic {IMM_I = 1'b0, IMM_B = 1'b1} imm_sel_t;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
endpackage

// File: rtl/rv_decode.sv
// rv_decode: classifies the latched instruction into legal / branch / bne for the sequencer.
module rv_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       legal,
    output logic       is_branch,
    output logic       is_bne
);
    assign is_bne = opcode == OPC_BRANCH && funct3 == F3_BNE;
    assign is_branch = is_bne || (opcode == OPC_BRANCH && funct3 == F3_BEQ);
    assign legal = is_branch || (opcode == OPC_OP_IMM && funct3 == F3_ADDI);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/WB sequencer with imem handshake, fault trap and retire counter.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             eq,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_src,
    output logic             reg_write,
    output logic             alu_ctrl,
    output logic             alu_src,
    output logic             imm_src,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);
    localparam int WT_W = FETCH_TIMEOUT > 2 ? $clog2(FETCH_TIMEOUT) : 1;
    ctrl_state_t state_q, state_d;
    logic [WT_W-1:0] wait_cnt;
    logic legal, is_branch, is_bne, retire, timeout;
    alu_op_t alu_op;
    imm_sel_t imm_sel;
    rv_decode u_dec (
        .opcode(opcode),
        .funct3(funct3),
        .legal(legal),
        .is_branch(is_branch),
        .is_bne(is_bne)
    );
    assign timeout = wait_cnt == WT_W'(FETCH_TIMEOUT - 1);
    assign alu_ctrl = alu_op;
    assign imm_src = imm_sel;
    assign state = state_q;
    assign fault = state_q == S_FAULT;
    always_comb begin
        state_d = S_FAULT;
        imem_req = 1'b0;
        ir_en = 1'b0;
        pc_en = 1'b0;
        pc_src = 1'b0;
        reg_write = 1'b0;
        alu_op = ADD;
        alu_src = 1'b0;
        imm_sel = IMM_I;
        retire = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en = imem_ack;
                state_d = imem_ack ? S_DECODE : timeout ? S_FAULT : S_FETCH;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                alu_op = is_branch ? SUB : ADD;
                alu_src = !is_branch;
                imm_sel = is_branch ? IMM_B : IMM_I;
                pc_en = legal && is_branch;
                pc_src = pc_en && (eq ^ is_bne);
                retire = pc_en;
                state_d = !legal ? S_FAULT : is_branch ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en = 1'b1;
                alu_src = 1'b1;
                retire = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_cnt <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH)
                wait_cnt <= (imem_ack || timeout) ? '0 : wait_cnt + WT_W'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end
endmodule
